// File: rtl/rob.sv
// Reorder buffer: circular buffer of renamed instructions that retires them
// in program order once execution completes. On commit it returns the old
// physical tag of the destination to the rename free pool.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   alloc_valid/reg_write/areg/preg/old_preg   allocation request from rename
//   alloc_ready, alloc_idx   combinational: !full and current tail tag
//   wb_valid, wb_idx         execution-complete strobe and ROB index
//   flush                    synchronous squash of every entry
//   commit_valid/areg/preg   registered retirement outputs
//   push_free_reg, freed_reg registered free-pool return
//   count, empty, full       occupancy (count registered; empty/full derived)
module rob #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PREG_WIDTH = 6,
  parameter int unsigned AREG_WIDTH = 5,
  parameter int unsigned IDX_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic                  alloc_reg_write,
  input  logic [AREG_WIDTH-1:0] alloc_areg,
  input  logic [PREG_WIDTH-1:0] alloc_preg,
  input  logic [PREG_WIDTH-1:0] alloc_old_preg,
  output logic                  alloc_ready,
  output logic [IDX_WIDTH-1:0]  alloc_idx,
  input  logic                  wb_valid,
  input  logic [IDX_WIDTH-1:0]  wb_idx,
  input  logic                  flush,
  output logic                  commit_valid,
  output logic [AREG_WIDTH-1:0] commit_areg,
  output logic [PREG_WIDTH-1:0] commit_preg,
  output logic                  push_free_reg,
  output logic [PREG_WIDTH-1:0] freed_reg,
  output logic [IDX_WIDTH:0]    count,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned CW = IDX_WIDTH + 1;

  logic [DEPTH-1:0]      ent_valid;
  logic [DEPTH-1:0]      ent_done;
  logic [DEPTH-1:0]      ent_reg_write;
  logic [AREG_WIDTH-1:0] ent_areg     [DEPTH];
  logic [PREG_WIDTH-1:0] ent_preg     [DEPTH];
  logic [PREG_WIDTH-1:0] ent_old_preg [DEPTH];

  logic [IDX_WIDTH-1:0]  head;
  logic [IDX_WIDTH-1:0]  tail;

  logic do_alloc;
  logic do_commit;

  // Occupancy flags and allocation handshake
  assign empty       = (count == CW'(0));
  assign full        = (count == CW'(DEPTH));
  assign alloc_ready = !full;
  assign alloc_idx   = tail;

  // Fullness and head done bit are both taken before this edge's update, so
  // a same-edge commit never frees a slot for a same-edge alloc, and a
  // writeback to the head only enables commit on the following edge.
  assign do_alloc  = alloc_valid && !full;
  assign do_commit = ent_valid[head] && ent_done[head];

  // Control state, occupancy and registered commit outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid     <= '0;
      ent_done      <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      commit_valid  <= 1'b0;
      commit_areg   <= '0;
      commit_preg   <= '0;
      push_free_reg <= 1'b0;
      freed_reg     <= '0;
    end else begin
      commit_valid  <= 1'b0;
      commit_areg   <= '0;
      commit_preg   <= '0;
      push_free_reg <= 1'b0;
      freed_reg     <= '0;
      if (flush) begin
        ent_valid <= '0;
        ent_done  <= '0;
        head      <= '0;
        tail      <= '0;
        count     <= '0;
      end else begin
        if (do_alloc) begin
          ent_valid[tail] <= 1'b1;
          ent_done[tail]  <= 1'b0;
          tail            <= tail + IDX_WIDTH'(1);
        end
        if (wb_valid && ent_valid[wb_idx]) begin
          ent_done[wb_idx] <= 1'b1;
        end
        // Placed after writeback so a retiring head entry ends fully cleared
        if (do_commit) begin
          ent_valid[head] <= 1'b0;
          ent_done[head]  <= 1'b0;
          head            <= head + IDX_WIDTH'(1);
          commit_valid    <= 1'b1;
          commit_areg     <= ent_areg[head];
          commit_preg     <= ent_preg[head];
          push_free_reg   <= ent_reg_write[head];
          freed_reg       <= ent_old_preg[head];
        end
        count <= count + CW'(do_alloc) - CW'(do_commit);
      end
    end
  end

  // Entry payload; only meaningful while the entry's valid bit is set.
  // x0 never owns a tag, so its old mapping is never returned.
  always_ff @(posedge clk) begin
    if (do_alloc && !flush) begin
      ent_reg_write[tail] <= alloc_reg_write && (alloc_areg != AREG_WIDTH'(0));
      ent_areg[tail]      <= alloc_areg;
      ent_preg[tail]      <= alloc_preg;
      ent_old_preg[tail]  <= alloc_old_preg;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: accepted allocations push their expected
// retirement record; a monitor pops and compares on every commit and checks
// that outputs are zero on cycles without one.
module tb_rob;

  logic       clk;
  logic       rst;
  logic       alloc_valid;
  logic       alloc_reg_write;
  logic [4:0] alloc_areg;
  logic [5:0] alloc_preg;
  logic [5:0] alloc_old_preg;
  logic       alloc_ready;
  logic [3:0] alloc_idx;
  logic       wb_valid;
  logic [3:0] wb_idx;
  logic       flush;
  logic       commit_valid;
  logic [4:0] commit_areg;
  logic [5:0] commit_preg;
  logic       push_free_reg;
  logic [5:0] freed_reg;
  logic [4:0] count;
  logic       empty;
  logic       full;

  rob #(.DEPTH(16), .PREG_WIDTH(6), .AREG_WIDTH(5), .IDX_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_reg_write(alloc_reg_write),
    .alloc_areg(alloc_areg), .alloc_preg(alloc_preg),
    .alloc_old_preg(alloc_old_preg), .alloc_ready(alloc_ready),
    .alloc_idx(alloc_idx), .wb_valid(wb_valid), .wb_idx(wb_idx),
    .flush(flush), .commit_valid(commit_valid), .commit_areg(commit_areg),
    .commit_preg(commit_preg), .push_free_reg(push_free_reg),
    .freed_reg(freed_reg), .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] areg;
    logic [5:0] preg;
    logic       push;
    logic [5:0] freed;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         vectors     = 0;
  int         miscompares = 0;
  int         n_commits   = 0;
  logic [3:0] m_tail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare every retirement against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (commit_valid) begin
        n_commits++;
        if (exp_q.size() == 0) begin
          check("unexpected_commit", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("commit_areg", 32'(commit_areg), 32'(mon_e.areg));
          check("commit_preg", 32'(commit_preg), 32'(mon_e.preg));
          check("push_free_reg", 32'(push_free_reg), 32'(mon_e.push));
          check("freed_reg", 32'(freed_reg), 32'(mon_e.freed));
        end
      end else begin
        check("idle_outputs", 32'({commit_areg, commit_preg, push_free_reg, freed_reg}), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic alloc(input logic [4:0] a, input logic [5:0] p, input logic [5:0] o,
                       input logic rw, input logic accept);
    alloc_valid     = 1'b1;
    alloc_reg_write = rw;
    alloc_areg      = a;
    alloc_preg      = p;
    alloc_old_preg  = o;
    check("alloc_ready", 32'(alloc_ready), 32'(accept));
    check("alloc_idx", 32'(alloc_idx), 32'(m_tail));
    if (accept) begin
      exp_q.push_back({a, p, rw && (a != 5'd0), o});
      m_tail++;
    end
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic wb(input logic [3:0] idx);
    wb_valid = 1'b1;
    wb_idx   = idx;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    m_tail = 4'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_commit_valid", 32'(commit_valid), 32'd0);
    check("rst_push_free", 32'(push_free_reg), 32'd0);
    check("rst_alloc_idx", 32'(alloc_idx), 32'd0);
    exp_q.delete();
    m_tail = 4'd0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int c0;
    logic [3:0] base;
    rst = 1'b0; alloc_valid = 1'b0; alloc_reg_write = 1'b0; alloc_areg = '0;
    alloc_preg = '0; alloc_old_preg = '0; wb_valid = 1'b0; wb_idx = '0; flush = 1'b0;
    m_tail = 4'd0;
    idle(2);
    do_reset();

    // Basic alloc / in-order writeback / commit
    c0 = n_commits;
    alloc(5'd1, 6'd32, 6'd1, 1'b1, 1'b1);
    alloc(5'd2, 6'd33, 6'd2, 1'b1, 1'b1);
    alloc(5'd3, 6'd34, 6'd3, 1'b1, 1'b1);
    check("count_3", 32'(count), 32'd3);
    wb(4'd0); wb(4'd1); wb(4'd2);
    idle(3);
    check("basic_commits", 32'(n_commits - c0), 32'd3);
    check("basic_count", 32'(count), 32'd0);
    check("basic_empty", 32'(empty), 32'd1);

    // Fill to capacity; extra alloc refused
    do_reset();
    c0 = n_commits;
    for (int i = 0; i < 16; i++)
      alloc(5'(i + 1), 6'(i + 16), 6'(i), 1'b1, 1'b1);
    check("full_flag", 32'(full), 32'd1);
    check("full_ready", 32'(alloc_ready), 32'd0);
    check("full_count", 32'(count), 32'd16);
    alloc(5'd31, 6'd63, 6'd63, 1'b1, 1'b0);
    check("full_count_after", 32'(count), 32'd16);
    check("full_tail_stays", 32'(alloc_idx), 32'd0);
    for (int i = 0; i < 16; i++) wb(4'(i));
    idle(3);
    check("full_commits", 32'(n_commits - c0), 32'd16);
    check("full_drained", 32'(count), 32'd0);

    // Reset mid-operation discards in-flight entries
    alloc(5'd4, 6'd40, 6'd4, 1'b1, 1'b1);
    alloc(5'd5, 6'd41, 6'd5, 1'b1, 1'b1);
    wb(4'd1);
    c0 = n_commits;
    do_reset();
    idle(2);
    check("midrst_no_commit", 32'(n_commits - c0), 32'd0);
    check("midrst_count", 32'(count), 32'd0);

    // Out-of-order completion retires in program order
    alloc(5'd6, 6'd20, 6'd9, 1'b1, 1'b1);
    alloc(5'd7, 6'd21, 6'd10, 1'b1, 1'b1);
    alloc(5'd8, 6'd22, 6'd11, 1'b1, 1'b1);
    c0 = n_commits;
    wb(4'd2); idle(1); wb(4'd1); idle(1);
    check("ooo_wait", 32'(n_commits - c0), 32'd0);
    wb(4'd0);
    idle(4);
    check("ooo_commits", 32'(n_commits - c0), 32'd3);

    // x0 destination retires without freeing a tag
    c0 = n_commits;
    base = m_tail;
    alloc(5'd0, 6'd40, 6'd5, 1'b1, 1'b1);
    wb(base);
    idle(3);
    check("x0_commits", 32'(n_commits - c0), 32'd1);

    // Flush with live and partially done entries
    base = m_tail;
    for (int i = 0; i < 5; i++)
      alloc(5'(i + 10), 6'(i + 50), 6'(i + 20), 1'b1, 1'b1);
    wb(base + 4'd1); wb(base + 4'd2);
    check("pre_flush_count", 32'(count), 32'd5);
    c0 = n_commits;
    do_flush();
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    idle(3);
    check("flush_no_commit", 32'(n_commits - c0), 32'd0);
    check("flush_alloc_idx", 32'(alloc_idx), 32'd0);
    alloc(5'd9, 6'd50, 6'd12, 1'b1, 1'b1);
    wb(4'd0);
    idle(2);

    // Wrap the pointers with a steady alloc/writeback stream
    c0 = n_commits;
    for (int i = 0; i < 20; i++) begin
      base = m_tail;
      alloc(5'((i % 30) + 1), 6'(i + 30), 6'(i + 1), 1'b1, 1'b1);
      wb(base);
    end
    idle(3);
    check("wrap_commits", 32'(n_commits - c0), 32'd20);
    check("wrap_count", 32'(count), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
